median3x3_stream: RTL and testbench
===================================

Name: median3x3_stream

Overview:
- Raster-scans a stored IMG_W x IMG_H 8-bit image through the image RAM read port.
- Builds a 3x3 window from two line buffers and outputs the median of that window for each interior pixel; this is the salt-and-pepper filtering stage.
- Results are written as address/data pairs to a downstream image RAM write port.
- Sits directly downstream of the image RAM and accounts for the RAM's fixed 2-cycle read latency.

Parameters:
- IMG_W, 256: image width in pixels.
- IMG_H, 256: image height in pixels.
- ADDR_W, $clog2(IMG_W*IMG_H): pixel index width. RAM address ports are ADDR_W+1 bits; the MSB is driven 0.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last output has been written.
- rd_en  out  1  image RAM read enable.
- rd_addr  out  ADDR_W+1  image RAM read address, equal to r*IMG_W+c.
- rd_data  in  8  image RAM read data, valid 2 cycles after rd_en.
- out_valid  out  1  output pixel strobe; connects to the downstream RAM wr_en.
- out_addr  out  ADDR_W+1  output pixel address.
- out_data  out  8  filtered pixel.

Behaviour:
- Reset: state=IDLE; busy, done, rd_en, out_valid = 0; out_addr, out_data, rd_addr = 0; scan counters = 0; all in-flight pipeline valids cleared. Line buffer contents are don't-care.
- FSM IDLE -> SCAN: on start.
- FSM SCAN: one scan point (r,c) per cycle over r in 0..IMG_H and c in 0..IMG_W, c fastest, giving (IMG_H+1)*(IMG_W+1) cycles.
  - rd_en=1 only when r<IMG_H and c<IMG_W.
  - Virtual points (r==IMG_H or c==IMG_W) issue no read and inject pixel value 0.
- FSM SCAN -> DRAIN: after point (IMG_H,IMG_W).
- FSM DRAIN: lasts PIPE_LAT cycles, then goes to DONE.
- FSM DONE: done=1 for one cycle, then IDLE. busy=0 in the DONE cycle.
- Tag pipeline: each scan point carries a 2-cycle tag delay line matching the RAM latency. When the tag emerges, rd_data (or 0 for a virtual point) is shifted into the window and line buffers.
- Line buffers: two, each IMG_W+1 deep, indexed by c.
- Window: the 3x3 window centred on (r-1,c-1) is formed when point (r,c) is shifted in. A center is produced only for r>=1 and c>=1.
- Border rule: if center row is 0 or IMG_H-1, or center column is 0 or IMG_W-1, out_data = center pixel unchanged. Otherwise out_data = median of the 9 window pixels.
- Latency: median9_sort has 3 registered stages. out_valid asserts exactly PIPE_LAT=6 cycles after the scan cycle of point (r,c), with out_addr=(r-1)*IMG_W+(c-1).
- Output count: exactly IMG_W*IMG_H out_valid pulses per frame, in raster order, no gaps within a row.
- start while busy: ignored.
- rst mid-frame: returns to IDLE next cycle. No further out_valid, and no done pulse for the aborted frame.
- start in the same cycle as rst: rst wins.
- out_addr never exceeds IMG_W*IMG_H-1.

Optional Feature:
- Macro IMPULSE_ONLY_EN.
- Defined: interior pixels are replaced by the median only when the center equals 0 or 255; all other centers pass through unchanged. Latency is unchanged, and the center is carried alongside the sorter stages.
- Undefined: every interior pixel is replaced by the median.

Decomposition:
- Package filter_pkg: pixel_t (logic [7:0]), state_t enum {IDLE,SCAN,DRAIN,DONE}, PIPE_LAT=6, RD_LAT=2, MED_STAGES=3, PIX_MIN=0, PIX_MAX=255.
- Sub-module median9_sort: 9 pixel_t inputs plus a valid. It is a 3-stage registered compare-exchange network and outputs the median plus a valid with fixed 3-cycle latency.
- Top: FSM, scan counters, tag delay line, line buffers, window, border select and optional impulse bypass.

Test Plan:
- All-128 8x8 image, start pulse -> exactly 64 out_valid, all out_data=128, addresses 0..63 in order. done pulses once, (9*9)+6 cycles after the scan begins.
- 8x8 of 100 with single 255 at (3,3) and single 0 at (5,2) -> those outputs = 100; all others 100.
- Ramp image pixel=r*8+c -> interior outputs equal the center (the median of a linear ramp); border outputs equal the input.
- Reset asserted at cycle 20 of a scan -> busy=0, out_valid=0 from the next cycle, no done pulse. A new start then yields a full correct frame.
- start pulses during SCAN and DRAIN -> ignored; exactly one frame of 64 outputs.
- IMPULSE_ONLY_EN defined, center 90 in a window of eight 200s -> output 90. Same window without the macro -> output 200.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared pixel/state types, pipeline constants and compare helpers for the median3x3 filter.
package filter_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam int unsigned PIPE_LAT   = 6;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned MED_STAGES = 3;
    localparam pixel_t      PIX_MIN    = 8'd0;
    localparam pixel_t      PIX_MAX    = 8'd255;

    function automatic pixel_t min2(input pixel_t a, input pixel_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pixel_t med3(input pixel_t a, input pixel_t b, input pixel_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

endpackage

// File: rtl/median9_sort.sv
// Three-stage registered median-of-nine: row sort, column reduction, final median of three.
module median9_sort
    import filter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  pixel_t win [9],
    output logic   out_valid,
    output pixel_t med
);

    pixel_t lo [3];
    pixel_t mid [3];
    pixel_t hi [3];
    pixel_t s2_lo, s2_mid, s2_hi;
    logic   v1, v2;

    // Median is med3(max of row mins, med of row meds, min of row maxes).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s2_lo     <= '0;
            s2_mid    <= '0;
            s2_hi     <= '0;
            med       <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                lo[i]  <= '0;
                mid[i] <= '0;
                hi[i]  <= '0;
            end
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            for (int unsigned i = 0; i < 3; i++) begin
                lo[i]  <= min2(min2(win[3*i], win[3*i+1]), win[3*i+2]);
                mid[i] <= med3(win[3*i], win[3*i+1], win[3*i+2]);
                hi[i]  <= max2(max2(win[3*i], win[3*i+1]), win[3*i+2]);
            end
            s2_lo  <= max2(max2(lo[0], lo[1]), lo[2]);
            s2_mid <= med3(mid[0], mid[1], mid[2]);
            s2_hi  <= min2(min2(hi[0], hi[1]), hi[2]);
            med    <= med3(s2_lo, s2_mid, s2_hi);
        end
    end

endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter reading one image RAM and writing another.
// Build option IMPULSE_ONLY_EN: only 0/255 centers are replaced by the median.
module median3x3_stream
    import filter_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [ADDR_W:0] rd_addr,
    input  pixel_t          rd_data,
    output logic            out_valid,
    output logic [ADDR_W:0] out_addr,
    output pixel_t          out_data
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int DW = $clog2(PIPE_LAT);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H);

    typedef struct packed {
        logic              valid;
        logic              zero;
        logic [CW-1:0]     col;
        logic              center;
        logic              border;
        logic [ADDR_W-1:0] addr;
    } tag_t;

    typedef struct packed {
        logic              border;
        logic [ADDR_W-1:0] addr;
        pixel_t            center;
    } side_t;

    state_t            state, state_next;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] pix_addr, ctr_addr;
    logic [DW-1:0]     drain_cnt;
    logic              last_point, center_ok, border_pt;

    assign last_point = (row == R_LAST) && (col == C_LAST);
    assign center_ok  = (row != '0) && (col != '0);
    assign border_pt  = (row == RW'(1)) || (row == R_LAST) || (col == CW'(1)) || (col == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE:  if (start) state_next = SCAN;
            SCAN: begin
                busy  = 1'b1;
                rd_en = (row < R_LAST) && (col < C_LAST);
                if (last_point) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DW'(PIPE_LAT - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters rest at zero whenever the scan is not running.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            row       <= '0;
            col       <= '0;
            pix_addr  <= '0;
            ctr_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == SCAN) begin
                if (col == C_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (rd_en)     pix_addr <= pix_addr + ADDR_W'(1);
                if (center_ok) ctr_addr <= ctr_addr + ADDR_W'(1);
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
        end
    end

    assign rd_addr = {1'b0, pix_addr};

    tag_t tag_in, tag_rd;
    tag_t tag_q [RD_LAT];

    always_comb begin
        tag_in        = '0;
        tag_in.valid  = (state == SCAN);
        tag_in.zero   = !rd_en;
        tag_in.col    = col;
        tag_in.center = center_ok;
        tag_in.border = border_pt;
        tag_in.addr   = ctr_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_rd = tag_q[RD_LAT-1];

    pixel_t new_px;
    pixel_t lb_up  [IMG_W+1];
    pixel_t lb_mid [IMG_W+1];
    pixel_t win_top [3];
    pixel_t win_mid [3];
    pixel_t win_bot [3];

    assign new_px = tag_rd.zero ? PIX_MIN : rd_data;

    // Line buffers hold rows r-2 and r-1; the new column enters at window index 2.
    always_ff @(posedge clk) begin
        if (tag_rd.valid) begin
            lb_up[tag_rd.col]  <= lb_mid[tag_rd.col];
            lb_mid[tag_rd.col] <= new_px;
            win_top[0] <= win_top[1];
            win_top[1] <= win_top[2];
            win_top[2] <= lb_up[tag_rd.col];
            win_mid[0] <= win_mid[1];
            win_mid[1] <= win_mid[2];
            win_mid[2] <= lb_mid[tag_rd.col];
            win_bot[0] <= win_bot[1];
            win_bot[1] <= win_bot[2];
            win_bot[2] <= new_px;
        end
    end

    logic              win_valid, win_border;
    logic [ADDR_W-1:0] win_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_addr   <= '0;
        end else begin
            win_valid  <= tag_rd.valid && tag_rd.center;
            win_border <= tag_rd.border;
            win_addr   <= tag_rd.addr;
        end
    end

    pixel_t win [9];
    pixel_t med;

    assign win = '{win_top[0], win_top[1], win_top[2],
                   win_mid[0], win_mid[1], win_mid[2],
                   win_bot[0], win_bot[1], win_bot[2]};

    median9_sort u_sort (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (win_valid),
        .win       (win),
        .out_valid (out_valid),
        .med       (med)
    );

    side_t side_q [MED_STAGES];
    side_t side_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MED_STAGES; i++) side_q[i] <= '0;
        end else begin
            side_q[0].border <= win_border;
            side_q[0].addr   <= win_addr;
            side_q[0].center <= win_mid[1];
            for (int unsigned i = 1; i < MED_STAGES; i++) side_q[i] <= side_q[i-1];
        end
    end

    assign side_out = side_q[MED_STAGES-1];

    logic use_med;

    always_comb begin
        use_med = !side_out.border;
`ifdef IMPULSE_ONLY_EN
        use_med = use_med && ((side_out.center == PIX_MIN) || (side_out.center == PIX_MAX));
`endif
    end

    assign out_data = use_med ? med : side_out.center;
    assign out_addr = {1'b0, side_out.addr};

endmodule

// File: tb/tb_median3x3_stream.sv
// Randomized/self-checking bench for median3x3_stream on an 8x8 image behind a 2-cycle RAM model.
module tb_median3x3_stream;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 6;
    localparam int N  = W * H;
    localparam int FIRST_OUT = (W + 1) + 1 + 6;
    localparam int DONE_AT   = (H + 1) * (W + 1) + 6;

`ifdef IMPULSE_ONLY_EN
    localparam bit IMPULSE_ONLY = 1'b1;
`else
    localparam bit IMPULSE_ONLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, rd_en, out_valid;
    logic [AW:0]   rd_addr, out_addr;
    logic [7:0]    rd_data, out_data;

    median3x3_stream #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Image RAM with two-cycle read latency; unread cycles return a marker value.
    logic [7:0] img [N];
    logic [7:0] ram_p1;
    always @(posedge clk) begin
        ram_p1  <= rd_en ? img[rd_addr[AW-1:0]] : 8'hA5;
        rd_data <= ram_p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_addr[$];
    int exp_data[$];
    int got_px [N];
    int n_out, n_done, n_rd, rd_next, first_cyc, done_cyc;

    task automatic build_expected();
        int win [9];
        int t, ctr, v;
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                ctr = int'(img[r*W + c]);
                v   = ctr;
                if (r > 0 && r < H-1 && c > 0 && c < W-1) begin
                    for (int i = 0; i < 9; i++)
                        win[i] = int'(img[(r - 1 + i/3)*W + (c - 1 + i%3)]);
                    for (int i = 0; i < 8; i++)
                        for (int j = 0; j < 8 - i; j++)
                            if (win[j] > win[j+1]) begin
                                t = win[j]; win[j] = win[j+1]; win[j+1] = t;
                            end
                    if (!IMPULSE_ONLY || ctr == 0 || ctr == 255) v = win[4];
                end
                exp_addr.push_back(r*W + c);
                exp_data.push_back(v);
            end
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_addr.size() == 0) begin
                check_eq("spurious_out_valid", 1, 0);
            end else begin
                check_eq("out_addr", int'(out_addr), exp_addr.pop_front());
                check_eq("out_data", int'(out_data), exp_data.pop_front());
            end
            if (int'(out_addr) < N) got_px[int'(out_addr)] = int'(out_data);
            if (n_out == 0) first_cyc = cyc;
            n_out++;
        end
        if (done) begin
            check_eq("busy_in_done", int'(busy), 0);
            n_done++;
            done_cyc = cyc;
        end
        if (rd_en) begin
            check_eq("rd_addr", int'(rd_addr), rd_next);
            rd_next++;
            n_rd++;
        end
    end

    task automatic clear_stats();
        n_out = 0; n_done = 0; n_rd = 0; rd_next = 0;
        first_cyc = -1; done_cyc = -1;
        for (int i = 0; i < N; i++) got_px[i] = -1;
    endtask

    task automatic run_frame(input bit extra_starts);
        int s, k;
        build_expected();
        clear_stats();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        s = cyc;
        check_eq("busy_after_start", int'(busy), 1);
        k = 0;
        while (n_done == 0 && k < 400) begin
            @(negedge clk);
            k++;
            start = extra_starts && (cyc == s + 30 || cyc == s + 83);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("done_count", n_done, 1);
        check_eq("done_cycle", done_cyc - s, DONE_AT);
        check_eq("first_out_cycle", first_cyc - s, FIRST_OUT);
        check_eq("out_count", n_out, N);
        check_eq("rd_count", n_rd, N);
        check_eq("pending_outputs", exp_addr.size(), 0);
        check_eq("busy_after_done", int'(busy), 0);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < N; i++) img[i] = 8'(v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       img[i] = 8'd0;
                1:       img[i] = 8'd255;
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    initial begin
        int s;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_rd_en", int'(rd_en), 0);
        check_eq("rst_rd_addr", int'(rd_addr), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_addr", int'(out_addr), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        rst = 1'b0;

        fill_const(128);
        run_frame(1'b0);
        check_eq("flat_px0", got_px[0], 128);
        check_eq("flat_px63", got_px[63], 128);

        fill_const(100);
        img[3*W + 3] = 8'd255;
        img[5*W + 2] = 8'd0;
        run_frame(1'b0);
        check_eq("salt_removed", got_px[3*W + 3], 100);
        check_eq("pepper_removed", got_px[5*W + 2], 100);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r*W + c] = 8'(r*W + c);
        run_frame(1'b0);
        check_eq("ramp_interior", got_px[3*W + 4], 3*W + 4);
        check_eq("ramp_corner", got_px[N-1], N-1);

        fill_const(200);
        img[3*W + 3] = 8'd90;
        run_frame(1'b0);
        check_eq("non_impulse_center", got_px[3*W + 3], IMPULSE_ONLY ? 90 : 200);

        fill_random();
        run_frame(1'b0);
        fill_random();
        run_frame(1'b1);

        // Abort a frame 20 cycles into the scan.
        fill_random();
        build_expected();
        clear_stats();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        s = cyc;
        while (cyc < s + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_out_valid", int'(out_valid), 0);
        #1;
        exp_addr.delete();
        exp_data.delete();
        n_done = 0;
        repeat (100) @(negedge clk);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_idle", int'(busy), 0);

        fill_random();
        run_frame(1'b0);

        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        check_eq("rst_wins_busy", int'(busy), 0);
        @(negedge clk);
        check_eq("rst_wins_rd_en", int'(rd_en), 0);
        check_eq("rst_wins_busy2", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
